// File: rtl/rv_pipe_pkg.sv
// Types and constants shared by the pipeline front end.
// A fetch entry holds one fetched instruction and its PC pair.
package rv_pipe_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_4;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fq_ptr_ctrl.sv
// Head/tail pointers and occupancy for the fetch queue.
// It also decides the enqueue and dequeue handshakes, with flush taking priority over both.
module fq_ptr_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PtrW  = $clog2(DEPTH),
    parameter int unsigned CntW  = $clog2(DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            fetch_ok_i,
    input  logic            deq_ready_i,
    output logic            enq_o,
    output logic            deq_o,
    output logic [PtrW-1:0] head_o,
    output logic [PtrW-1:0] tail_o,
    output logic [CntW-1:0] count_o,
    output logic            empty_o
);

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            empty, full;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(DEPTH));

    // A full queue still accepts a fetch when the head leaves in the same cycle.
    assign deq_o = !empty && deq_ready_i && !flush_i;
    assign enq_o = fetch_ok_i && !flush_i && (!full || deq_o);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_o) begin
                tail_d = tail_q + PtrW'(1);
            end
            if (deq_o) begin
                head_d = head_q + PtrW'(1);
            end
            count_d = count_q + CntW'(enq_o) - CntW'(deq_o);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;
    assign empty_o = empty;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, drives the icache and buffers
// fetched instructions for decode, emitting NOP bubbles when empty.
module instr_fetch_queue
    import rv_pipe_pkg::*;
#(
    parameter int unsigned    XLEN     = 32,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [XLEN-1:0]          flush_pc,
    output logic [XLEN-1:0]          icache_addr,
    input  logic [XLEN-1:0]          icache_rdata,
    input  logic                     icache_busywait,
    input  logic                     deq_ready,
    output logic                     deq_valid,
    output logic [XLEN-1:0]          deq_pc,
    output logic [XLEN-1:0]          deq_pc_4,
    output logic [XLEN-1:0]          deq_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            enq, deq, empty;
    logic [PtrW-1:0] head, tail;
    logic [CntW-1:0] count_w;
    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    head_entry;

    fq_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PtrW  (PtrW),
        .CntW  (CntW)
    ) u_ptr_ctrl (
        .clk_i       (clk),
        .rst_ni      (reset),
        .flush_i     (flush),
        .fetch_ok_i  (!icache_busywait),
        .deq_ready_i (deq_ready),
        .enq_o       (enq),
        .deq_o       (deq),
        .head_o      (head),
        .tail_o      (tail),
        .count_o     (count_w),
        .empty_o     (empty)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (flush) begin
            fetch_pc_d = flush_pc;
        end else if (enq) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Storage is left unreset; entries are only visible through count.
    always_ff @(posedge clk) begin
        if (reset && enq) begin
            mem_q[tail] <= '{pc: fetch_pc_q, pc_4: fetch_pc_q + XLEN'(4), instr: icache_rdata};
        end
    end

    assign head_entry  = mem_q[head];
    assign icache_addr = fetch_pc_q;
    assign count       = count_w;
    assign deq_valid   = !empty;
    assign deq_pc      = empty ? '0 : head_entry.pc;
    assign deq_pc_4    = empty ? '0 : head_entry.pc_4;
    assign deq_instr   = empty ? NOP_INSTR : head_entry.instr;

    logic unused_deq;
    assign unused_deq = deq;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a behavioural scoreboard of expected
// PCs is updated every cycle and compared against the head outputs.
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] icache_addr;
    logic [31:0] icache_rdata;
    logic        icache_busywait;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_pc_4;
    logic [31:0] deq_instr;
    logic [2:0]  count;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] sb [$];
    logic [31:0] mpc;

    instr_fetch_queue #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .icache_addr     (icache_addr),
        .icache_rdata    (icache_rdata),
        .icache_busywait (icache_busywait),
        .deq_ready       (deq_ready),
        .deq_valid       (deq_valid),
        .deq_pc          (deq_pc),
        .deq_pc_4        (deq_pc_4),
        .deq_instr       (deq_instr),
        .count           (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
    endfunction

    always_comb icache_rdata = imem(icache_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        logic [31:0] h;
        chk("count", {29'd0, count}, sb.size());
        chk("icache_addr", icache_addr, mpc);
        if (sb.size() == 0) begin
            chk("deq_valid", {31'd0, deq_valid}, 32'd0);
            chk("deq_pc", deq_pc, 32'd0);
            chk("deq_pc_4", deq_pc_4, 32'd0);
            chk("deq_instr", deq_instr, NOP);
        end else begin
            h = sb[0];
            chk("deq_valid", {31'd0, deq_valid}, 32'd1);
            chk("deq_pc", deq_pc, h);
            chk("deq_pc_4", deq_pc_4, h + 32'd4);
            chk("deq_instr", deq_instr, imem(h));
        end
    endtask

    // Advance the model by the inputs currently applied, clock once, then compare.
    task automatic cycle();
        int sz;
        bit md, me;
        sz = sb.size();
        if (!reset) begin
            sb.delete();
            mpc = RESET_PC;
        end else if (flush) begin
            sb.delete();
            mpc = flush_pc;
        end else begin
            md = (sz != 0) && deq_ready;
            me = !icache_busywait && ((sz < DEPTH) || md);
            if (md) void'(sb.pop_front());
            if (me) begin
                sb.push_back(mpc);
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; flush_pc = '0;
        icache_busywait = 1'b0; deq_ready = 1'b0;
        mpc = RESET_PC;

        // Reset and fill
        cycles(2);
        reset = 1'b1;
        cycles(6);
        chk("fill_count", {29'd0, count}, 32'd4);
        chk("fill_addr", icache_addr, 32'd16);
        chk("fill_pc", deq_pc, 32'd0);
        chk("fill_instr", deq_instr, imem(32'd0));

        // Streaming at one per cycle
        reset = 1'b0; cycle();
        reset = 1'b1; deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("stream_count", {29'd0, count}, 32'd1);
        end

        // Miss stall at address 8
        reset = 1'b0; cycle();
        reset = 1'b1;
        cycles(2);
        chk("miss_addr0", icache_addr, 32'd8);
        icache_busywait = 1'b1;
        cycles(5);
        chk("miss_addr", icache_addr, 32'd8);
        chk("miss_valid", {31'd0, deq_valid}, 32'd0);
        chk("miss_nop", deq_instr, NOP);
        icache_busywait = 1'b0;
        cycle();
        chk("miss_resume_pc", deq_pc, 32'd8);
        cycles(3);

        // Flush with three entries queued
        reset = 1'b0; cycle();
        reset = 1'b1; deq_ready = 1'b0;
        cycles(3);
        chk("pre_flush_count", {29'd0, count}, 32'd3);
        flush = 1'b1; flush_pc = 32'h100; deq_ready = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_count", {29'd0, count}, 32'd0);
        chk("flush_addr", icache_addr, 32'h100);
        chk("flush_valid", {31'd0, deq_valid}, 32'd0);
        cycle();
        chk("flush_first_pc", deq_pc, 32'h100);
        cycles(2);

        // Flush during a miss, to a misaligned target
        icache_busywait = 1'b1;
        cycles(2);
        flush = 1'b1; flush_pc = 32'h202;
        cycle();
        flush = 1'b0;
        cycles(2);
        icache_busywait = 1'b0;
        cycles(3);

        // Full with simultaneous enqueue and dequeue, across pointer wrap
        deq_ready = 1'b0;
        cycles(4);
        deq_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("full_count", {29'd0, count}, 32'd4);
        end

        // Fetch PC wraps at the top of the address space
        flush = 1'b1; flush_pc = 32'hFFFF_FFF8;
        cycle();
        flush = 1'b0;
        cycles(5);

        // Reset in the middle of a miss
        icache_busywait = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_addr", icache_addr, RESET_PC);
        chk("rst_valid", {31'd0, deq_valid}, 32'd0);
        icache_busywait = 1'b0;
        cycles(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Parametrised successor to the single-entry IF stage of the 5-stage RISC-V pipeline.
- Owns the fetch PC and drives the instruction cache (icache) address.
- Buffers up to DEPTH fetched {pc, pc+4, instruction} entries, so icache misses and decode stalls are decoupled.
- Sits between the icache and the decode stage. Supports branch/jump flush with redirect, and inserts NOP bubbles when empty.

Parameters:
- XLEN, 32, width of PC and instruction words.
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low (reset=0 resets on the next rising clk).
- flush  in  1  branch/jump taken from execute; redirects fetch.
- flush_pc  in  XLEN  redirect target; valid when flush=1.
- icache_addr  out  XLEN  fetch address to icache (= fetch PC register).
- icache_rdata  in  XLEN  instruction from icache; valid when icache_busywait=0.
- icache_busywait  in  1  icache miss in progress.
- deq_ready  in  1  decode stage accepts head entry this cycle (0 while pipeline stalled).
- deq_valid  out  1  head entry present.
- deq_pc  out  XLEN  PC of head instruction.
- deq_pc_4  out  XLEN  deq_pc+4.
- deq_instr  out  XLEN  head instruction; NOP 32'h0000_0013 when deq_valid=0.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
Reset (reset=0 at clk edge):
- fetch_pc=RESET_PC, count=0, head/tail pointers=0.
- deq_valid=0, deq_instr=NOP, deq_pc=0, deq_pc_4=0.
- Storage contents need not be cleared.

Address path:
- icache_addr = fetch_pc, combinational from register; stable throughout a miss.

Enqueue condition (enq):
- enq = icache_busywait==0 && flush==0 && (count<DEPTH || deq).
- On enq: store {fetch_pc, fetch_pc+4, icache_rdata} at tail; tail+1 (mod DEPTH); fetch_pc += 4 (wraps mod 2^XLEN).

Dequeue condition (deq):
- deq = deq_valid && deq_ready && flush==0. On deq: head+1 (mod DEPTH).

Occupancy:
- count_next = count + enq − deq.
- When full, simultaneous enq and deq is allowed; count stays at DEPTH.
- When empty, no same-cycle bypass: an instruction enqueued in cycle N is visible at the outputs in cycle N+1 at the earliest.

Outputs:
- deq_valid = (count!=0).
- deq_pc, deq_pc_4, deq_instr read from head. All three are forced to 0/0/NOP when empty.

Flush (flush=1):
- Next cycle: count=0, head=tail=0, fetch_pc=flush_pc.
- Icache data arriving in the flush cycle is discarded.
- deq_ready is ignored in the flush cycle.
- Flush has priority over enq and deq.
- Flush during an icache miss: the address changes the next cycle; any later returned data is for the new address only.

Priority:
- reset > flush > enq/deq.

Misalignment:
- flush_pc[1:0]≠0 is accepted as-is; no trap is raised.

Latency:
- Icache hit to deq_valid: 1 cycle.
- Flush to first redirected instruction valid: 2 cycles, assuming an icache hit.

Throughput:
- 1 instruction/cycle sustained when the icache hits and deq_ready=1.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - NOP_INSTR = 32'h0000_0013;
  - default RESET_PC;
  - typedef fetch_entry_t {pc, pc_4, instr}.
- One sub-module: fq_ptr_ctrl. It owns the head/tail pointers, count, and the full/empty logic, parametrised by DEPTH.
- Storage and PC logic stay in the top block.

Test Plan:
1. Reset and fill: hold reset=0 for 2 cycles, then release with RESET_PC=0, busywait=0, deq_ready=0.
   - icache_addr steps 0,4,8,12 and then holds at 16.
   - count reaches 4; deq_valid=1, deq_pc=0, deq_instr=first word.
2. Streaming: busywait=0, deq_ready=1 from reset.
   - One dequeue per cycle with deq_pc 0,4,8,… and deq_pc_4 = deq_pc+4.
   - count stays at 1 and never reaches DEPTH.
3. Miss stall: busywait=1 for 5 cycles at addr 8.
   - icache_addr stays at 8; the queue drains; deq_instr=NOP with deq_valid=0 once empty.
   - After busywait falls, addr 8 is enqueued exactly once.
4. Flush: queue holding 3 entries; flush=1 with flush_pc=0x100 and deq_ready=1.
   - Next cycle: count=0, icache_addr=0x100, deq_valid=0.
   - Two cycles later: deq_pc=0x100.
5. Full with simultaneous enq/deq: count=4, busywait=0, deq_ready=1.
   - count stays 4; tail and head both advance; FIFO order is preserved across pointer wrap.
6. Reset mid-miss: busywait=1 with queue non-empty; assert reset=0 for 1 cycle.
   - Next cycle: count=0, icache_addr=RESET_PC, deq_valid=0.
